aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 144 ++++++++++++++
 rtl/aes_cipher.sv | 30 +++
 rtl/aes_inv_round.sv | 17 +
 rtl/aes_key_expansion.sv | 41 ++++
 rtl/aes_inv_cipher_iter.sv | 122 ++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-box functions, round transforms
// and the FSM state type used by the iterative inverse cipher.
package aes_pkg;

  localparam int AES_BLOCK = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } inv_fsm_t;

  // AES-128/192/256 use Nk = 4/6/8 key words and Nr = Nk + 6 rounds
  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

  // Bit position of byte i; byte 0 sits in the top eight bits of the block
  function automatic int bpos(input int i);
    return AES_BLOCK - 1 - 8 * i;
  endfunction

  function automatic logic [7:0] gf28_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0
  function automatic logic [7:0] gf28_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf28_mul(p, p);
      r = gf28_mul(r, p);
    end
    return r;
  endfunction

  // S-box derived from its definition: field inverse then affine map
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf28_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine map then field inverse
  function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf28_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [AES_BLOCK-1:0] add_round_key(input logic [AES_BLOCK-1:0] s,
                                                         input logic [AES_BLOCK-1:0] k);
    return s ^ k;
  endfunction

  function automatic logic [AES_BLOCK-1:0] sub_bytes(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[bpos(i) -: 8] = sub_byte(s[bpos(i) -: 8]);
    return o;
  endfunction

  function automatic logic [AES_BLOCK-1:0] inv_sub_bytes(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[bpos(i) -: 8] = inv_sub_byte(s[bpos(i) -: 8]);
    return o;
  endfunction

  // Byte (r,c) is index r + 4c; row r rotates left by r columns
  function automatic logic [AES_BLOCK-1:0] shift_rows(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[bpos(r + 4 * c) -: 8] = s[bpos(r + 4 * ((c + r) % 4)) -: 8];
    return o;
  endfunction

  // Row r rotates right by r columns, undoing shift_rows
  function automatic logic [AES_BLOCK-1:0] inv_shift_rows(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[bpos(r + 4 * c) -: 8] = s[bpos(r + 4 * ((c - r + 4) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [AES_BLOCK-1:0] mix_columns(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[bpos(4 * c) -: 8];
      a1 = s[bpos(4 * c + 1) -: 8];
      a2 = s[bpos(4 * c + 2) -: 8];
      a3 = s[bpos(4 * c + 3) -: 8];
      o[bpos(4 * c) -: 8]     = gf28_mul(a0, 8'h02) ^ gf28_mul(a1, 8'h03) ^ a2 ^ a3;
      o[bpos(4 * c + 1) -: 8] = a0 ^ gf28_mul(a1, 8'h02) ^ gf28_mul(a2, 8'h03) ^ a3;
      o[bpos(4 * c + 2) -: 8] = a0 ^ a1 ^ gf28_mul(a2, 8'h02) ^ gf28_mul(a3, 8'h03);
      o[bpos(4 * c + 3) -: 8] = gf28_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf28_mul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [AES_BLOCK-1:0] inv_mix_columns(input logic [AES_BLOCK-1:0] s);
    logic [AES_BLOCK-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[bpos(4 * c) -: 8];
      a1 = s[bpos(4 * c + 1) -: 8];
      a2 = s[bpos(4 * c + 2) -: 8];
      a3 = s[bpos(4 * c + 3) -: 8];
      o[bpos(4 * c) -: 8]     = gf28_mul(a0, 8'h0e) ^ gf28_mul(a1, 8'h0b) ^
                                gf28_mul(a2, 8'h0d) ^ gf28_mul(a3, 8'h09);
      o[bpos(4 * c + 1) -: 8] = gf28_mul(a0, 8'h09) ^ gf28_mul(a1, 8'h0e) ^
                                gf28_mul(a2, 8'h0b) ^ gf28_mul(a3, 8'h0d);
      o[bpos(4 * c + 2) -: 8] = gf28_mul(a0, 8'h0d) ^ gf28_mul(a1, 8'h09) ^
                                gf28_mul(a2, 8'h0e) ^ gf28_mul(a3, 8'h0b);
      o[bpos(4 * c + 3) -: 8] = gf28_mul(a0, 8'h0b) ^ gf28_mul(a1, 8'h0d) ^
                                gf28_mul(a2, 8'h09) ^ gf28_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_cipher.sv
// Combinational AES forward cipher built from the shared helpers.
module aes_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_for_nk(Nk)
) (
  input  logic [AES_BLOCK-1:0] data_in,
  input  logic [Nk*32-1:0]     key,
  output logic [AES_BLOCK-1:0] data_out
);

  logic [(Nr+1)*AES_BLOCK-1:0] w;

  aes_key_expansion #(.Nk(Nk), .Nr(Nr)) u_kexp (
    .key (key),
    .w   (w)
  );

  // Fully unrolled rounds; the last round skips MixColumns
  always_comb begin
    logic [AES_BLOCK-1:0] s;
    s = add_round_key(data_in, w[(Nr+1)*AES_BLOCK-1 -: AES_BLOCK]);
    for (int r = 1; r < Nr; r++)
      s = add_round_key(mix_columns(shift_rows(sub_bytes(s))),
                        w[(Nr+1)*AES_BLOCK-1-r*AES_BLOCK -: AES_BLOCK]);
    data_out = add_round_key(shift_rows(sub_bytes(s)), w[AES_BLOCK-1:0]);
  end

endmodule

// File: rtl/aes_inv_round.sv
// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey and, except in
// the final round, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK-1:0] state,
  input  logic [AES_BLOCK-1:0] round_key,
  input  logic                 last,
  output logic [AES_BLOCK-1:0] next_state
);

  logic [AES_BLOCK-1:0] pre_mix;

  assign pre_mix    = add_round_key(inv_sub_bytes(inv_shift_rows(state)), round_key);
  assign next_state = last ? pre_mix : inv_mix_columns(pre_mix);

endmodule

// File: rtl/aes_key_expansion.sv
// Combinational AES key schedule. Word 0 of the schedule occupies the top
// 32 bits of w, so round key r is w[(Nr+1)*128-1-r*128 -: 128].
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_for_nk(Nk)
) (
  input  logic [Nk*32-1:0]            key,
  output logic [(Nr+1)*AES_BLOCK-1:0] w
);

  function automatic logic [(Nr+1)*AES_BLOCK-1:0] expand(input logic [Nk*32-1:0] k);
    logic [31:0] wd [4*(Nr+1)];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [(Nr+1)*AES_BLOCK-1:0] o;
    rcon = 8'h01;
    t    = '0;
    o    = '0;
    for (int i = 0; i < 4 * (Nr + 1); i++) begin
      if (i < Nk) begin
        wd[i] = k[Nk*32-1-32*i -: 32];
      end else begin
        t = wd[i-1];
        if (i % Nk == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = gf28_mul(rcon, 8'h02);
        end else if (Nk > 6 && i % Nk == 4) begin
          t = sub_word(t);
        end
        wd[i] = wd[i-Nk] ^ t;
      end
      o[(Nr+1)*AES_BLOCK-1-32*i -: 32] = wd[i];
    end
    return o;
  endfunction

  assign w = expand(key);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption: one inverse round per clock on a shared round
// datapath, valid/ready handshakes on both sides, one job in flight.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_for_nk(Nk)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLOCK-1:0] data_in,
  input  logic [Nk*32-1:0]     key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLOCK-1:0] data_out,
  output logic                 busy
);

  localparam logic [3:0] RND_INIT = 4'(Nr - 1);
  localparam logic [3:0] RND_LAST = 4'(Nr);

  inv_fsm_t                    fsm, fsm_nxt;
  logic [AES_BLOCK-1:0]        state_q;
  logic [Nk*32-1:0]            key_q;
  logic [3:0]                  rnd;
  logic [3:0]                  rk_idx;
  logic [(Nr+1)*AES_BLOCK-1:0] w;
  logic [AES_BLOCK-1:0]        rk;
  logic [AES_BLOCK-1:0]        round_out;
  logic                        accept;

  assign accept = in_valid && in_ready;

  // Schedule is derived from the latched key so the key port may change mid-job
  aes_key_expansion #(.Nk(Nk), .Nr(Nr)) u_kexp (
    .key (key_q),
    .w   (w)
  );

  // LOAD whitens with the last round key; ROUND walks rnd down to 0
  assign rk_idx = (fsm == S_LOAD) ? RND_LAST : rnd;
  assign rk     = w[(Nr+1)*AES_BLOCK-1 - 32'(rk_idx)*AES_BLOCK -: AES_BLOCK];

  aes_inv_round u_round (
    .state      (state_q),
    .round_key  (rk),
    .last       (rnd == 4'd0),
    .next_state (round_out)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_nxt;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (rnd == 4'd0) fsm_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) fsm_nxt = S_IDLE;
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  // Key register captures only on an accepted job
  always_ff @(posedge clk) begin
    if (accept && !rst) key_q <= key;
  end

  // Block state, round counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      rnd       <= 4'd0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) state_q <= data_in;
        end
        S_LOAD: begin
          state_q <= add_round_key(state_q, rk);
          rnd     <= RND_INIT;
        end
        S_ROUND: begin
          if (rnd != 4'd0) begin
            state_q <= round_out;
            rnd     <= rnd - 4'd1;
          end else begin
            data_out  <= round_out;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES inverse cipher: FIPS-197 vectors for AES-128
// and AES-256, back-pressure, busy-time input changes, abort via reset and a
// forward-cipher round trip, all checked through a plaintext scoreboard.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in, data_out, key;

  logic         v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_busy;
  logic [127:0] v8_data_in, v8_data_out;
  logic [255:0] v8_key;

  logic [127:0] rt_key, rt_pt, rt_ct;

  int           total = 0;
  int           bad   = 0;
  int           n_sent = 0;
  int           n_out  = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) dut256 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8_in_valid),
    .in_ready  (v8_in_ready),
    .data_in   (v8_data_in),
    .key       (v8_key),
    .out_valid (v8_out_valid),
    .out_ready (v8_out_ready),
    .data_out  (v8_data_out),
    .busy      (v8_busy)
  );

  aes_cipher #(.Nk(4), .Nr(10)) enc (
    .data_in  (rt_pt),
    .key      (rt_key),
    .data_out (rt_ct)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job, wait for acceptance, record the expected plaintext
  task automatic send(input logic [127:0] k, input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    in_valid = 1'b1;
    key      = k;
    data_in  = d;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 128'(n), 128'd0);
    end else begin
      sb.push_back(e);
      n_sent++;
      tick();
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) chk("sb_empty", 128'(sb.size()), 128'd1);
      else                chk("sb_data", data_out, sb.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; data_in = '0; key = '0;
    v8_in_valid = 1'b0; v8_out_ready = 1'b1; v8_data_in = '0; v8_key = '0;
    rt_key = '0; rt_pt = '0;
    tick();
    tick();
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_data_out",  data_out,        128'd0);
    chk("rst_v8_ready",  128'(v8_in_ready), 128'd1);
    rst = 1'b0;
    tick();

    // FIPS-197 Appendix B with latency check
    send(KEY_B, CT_B, PT_B);
    in_valid = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'd1);
    wait_valid(n);
    chk("lat128", 128'(n), 128'd11);
    tick();

    // Appendix C.1 with the input ports scrambled while busy
    send(KEY_C, CT_C1, PT_C);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      key     = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    wait_valid(n);
    chk("lat_c1", 128'(n), 128'd5);
    tick();

    // Appendix C.3 on the AES-256 instance
    v8_in_valid = 1'b1; v8_key = KEY_C3; v8_data_in = CT_C3;
    n = 0;
    while (!v8_in_ready && n < 50) begin tick(); n++; end
    tick();
    v8_in_valid = 1'b0;
    n = 0;
    while (!v8_out_valid && n < 100) begin tick(); n++; end
    chk("lat256", 128'(n), 128'd15);
    chk("c3_data", v8_data_out, PT_C);

    // Back-pressure: result held until out_ready
    out_ready = 1'b0;
    send(KEY_B, CT_B, PT_B);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_lat", 128'(n), 128'd11);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", data_out, PT_B);
      chk("bp_flags", 128'({out_valid, in_ready, busy}), 128'(3'b100));
      tick();
    end
    n0 = n_out;
    out_ready = 1'b1;
    tick();
    chk("bp_one_hs", 128'(n_out - n0), 128'd1);
    chk("bp_release", 128'({out_valid, in_ready}), 128'(2'b01));
    tick();
    chk("bp_no_dup", 128'(n_out - n0), 128'd1);

    // Abort in the middle of round 5, then a fresh job
    send(KEY_C, CT_C1, PT_C);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    void'(sb.pop_back());
    n_sent--;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_data_out",  data_out,        128'd0);
    chk("abort_in_ready",  128'(in_ready),  128'd1);
    chk("abort_busy_low",  128'(busy),      128'd0);
    send(KEY_B, CT_B, PT_B);
    in_valid = 1'b0;
    wait_valid(n);
    chk("post_abort_lat", 128'(n), 128'd11);
    tick();

    // Round trip through the forward cipher with in_valid held high
    for (int j = 0; j < 1000; j++) begin
      rt_key = {$urandom(), $urandom(), $urandom(), $urandom()};
      rt_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      send(rt_key, rt_ct, rt_pt);
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 200) begin tick(); n++; end
    tick();
    chk("sb_left", 128'(sb.size()), 128'd0);
    chk("job_count", 128'(n_out), 128'(n_sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
